// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: FSM states, opcodes,
// funct codes, ALU control codes and datapath mux select codes.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
    EXECUTE, ALUWB, BRANCH, ADDIEXEC, ADDIWB, JUMP
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // True for the R-type functions the datapath ALU can execute.
  function automatic logic isAluFunct(input logic [5:0] funct);
    return (funct == FUNCT_ADD) || (funct == FUNCT_SUB) || (funct == FUNCT_AND) ||
           (funct == FUNCT_OR)  || (funct == FUNCT_SLT);
  endfunction

endpackage

// File: rtl/mips_multicycle_ctrl_alu_decoder.sv
// Combinational ALU decoder: the FSM's ALUOp class plus the R-type funct
// field select the 3-bit ALUControl code.
module alu_decoder
  import mips_ctrl_pkg::*;
(
  input  logic [1:0] ALUOp,
  input  logic [5:0] Funct,
  output logic [2:0] ALUControl
);

  always_comb begin
    ALUControl = ALU_ADD;
    case (ALUOp)
      ALUOP_SUB: ALUControl = ALU_SUB;
      ALUOP_FUNCT: begin
        case (Funct)
          FUNCT_SUB: ALUControl = ALU_SUB;
          FUNCT_AND: ALUControl = ALU_AND;
          FUNCT_OR:  ALUControl = ALU_OR;
          FUNCT_SLT: ALUControl = ALU_SLT;
          default:   ALUControl = ALU_ADD;
        endcase
      end
      default: ALUControl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Moore FSM controller for the shared-ALU multi-cycle MIPS datapath.
// Define MIPS_BNE_EN to decode bne (Op 000101) as a branch on ~Zero.
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] Op,
  input  logic [5:0] Funct,
  input  logic       Zero,
  input  logic       mem_ready,
  output logic       PCEn,
  output logic       IorD,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSrc,
  output logic [2:0] ALUControl,
  output logic       instr_done,
  output logic       illegal_op
);

  state_t     stateReg, stateNext, decodeNext;
  logic       opLegal;
  logic       pcWrite, branch, branchCond;
  logic [1:0] aluOp;

  alu_decoder uAluDecoder (
    .ALUOp      (aluOp),
    .Funct      (Funct),
    .ALUControl (ALUControl)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) stateReg <= FETCH;
    else       stateReg <= stateNext;
  end

  // Op/Funct dispatch out of DECODE; anything unrecognised is retired as illegal.
  always_comb begin
    decodeNext = FETCH;
    opLegal    = 1'b1;
    case (Op)
      OP_RTYPE: begin
        if (isAluFunct(Funct)) decodeNext = EXECUTE;
        else                   opLegal    = 1'b0;
      end
      OP_LW, OP_SW: decodeNext = MEMADR;
      OP_BEQ:       decodeNext = BRANCH;
`ifdef MIPS_BNE_EN
      OP_BNE:       decodeNext = BRANCH;
`endif
      OP_ADDI:      decodeNext = ADDIEXEC;
      OP_J:         decodeNext = JUMP;
      default:      opLegal    = 1'b0;
    endcase
  end

  always_comb begin
    stateNext = FETCH;
    case (stateReg)
      FETCH:    stateNext = mem_ready ? DECODE : FETCH;
      DECODE:   stateNext = decodeNext;
      MEMADR:   stateNext = (Op == OP_SW) ? MEMWRITE : MEMREAD;
      MEMREAD:  stateNext = mem_ready ? MEMWB : MEMREAD;
      MEMWRITE: stateNext = mem_ready ? FETCH : MEMWRITE;
      EXECUTE:  stateNext = ALUWB;
      ADDIEXEC: stateNext = ADDIWB;
      default:  stateNext = FETCH;
    endcase
  end

  // IR still holds the branch opcode in BRANCH, so it picks the condition sense.
`ifdef MIPS_BNE_EN
  assign branchCond = (Op == OP_BNE) ? ~Zero : Zero;
`else
  assign branchCond = Zero;
`endif

  always_comb begin
    IorD       = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    RegDst     = 1'b0;
    MemtoReg   = 1'b0;
    RegWrite   = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = SRCB_B;
    PCSrc      = PCSRC_ALU;
    aluOp      = ALUOP_ADD;
    pcWrite    = 1'b0;
    branch     = 1'b0;
    instr_done = 1'b0;
    illegal_op = 1'b0;
    case (stateReg)
      FETCH: begin
        ALUSrcB = SRCB_FOUR;
        IRWrite = mem_ready;
        pcWrite = mem_ready;
      end
      DECODE: begin
        ALUSrcB    = SRCB_IMMSH;
        illegal_op = ~opLegal;
        instr_done = ~opLegal;
      end
      MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
      end
      MEMREAD: IorD = 1'b1;
      MEMWRITE: begin
        IorD       = 1'b1;
        MemWrite   = 1'b1;
        instr_done = mem_ready;
      end
      MEMWB: begin
        MemtoReg   = 1'b1;
        RegWrite   = 1'b1;
        instr_done = 1'b1;
      end
      EXECUTE: begin
        ALUSrcA = 1'b1;
        aluOp   = ALUOP_FUNCT;
      end
      ALUWB: begin
        RegDst     = 1'b1;
        RegWrite   = 1'b1;
        instr_done = 1'b1;
      end
      BRANCH: begin
        ALUSrcA    = 1'b1;
        aluOp      = ALUOP_SUB;
        PCSrc      = PCSRC_ALUOUT;
        branch     = 1'b1;
        instr_done = 1'b1;
      end
      ADDIEXEC: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
      end
      ADDIWB: begin
        RegWrite   = 1'b1;
        instr_done = 1'b1;
      end
      JUMP: begin
        PCSrc      = PCSRC_JUMP;
        pcWrite    = 1'b1;
        instr_done = 1'b1;
      end
      default: ;
    endcase
    // Reset forces FETCH; also squash every strobe so nothing writes while held.
    if (reset) begin
      IRWrite    = 1'b0;
      MemWrite   = 1'b0;
      RegWrite   = 1'b0;
      pcWrite    = 1'b0;
      branch     = 1'b0;
      instr_done = 1'b0;
      illegal_op = 1'b0;
    end
  end

  assign PCEn = pcWrite | (branch & branchCond);

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Self-checking bench for mips_multicycle_ctrl: directed spec cases plus random
// instructions checked against per-instruction expectations (latency, strobe counts).
module tb_mips_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] Op, Funct;
  logic       Zero, mem_ready;
  logic       PCEn, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB, PCSrc;
  logic [2:0] ALUControl;
  logic       instr_done, illegal_op;

  int tests = 0;
  int failures = 0;

`ifdef MIPS_BNE_EN
  localparam bit BNE_EN = 1'b1;
`else
  localparam bit BNE_EN = 1'b0;
`endif

  mips_multicycle_ctrl dut (
    .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Zero(Zero), .mem_ready(mem_ready),
    .PCEn(PCEn), .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite), .RegDst(RegDst),
    .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .PCSrc(PCSrc), .ALUControl(ALUControl), .instr_done(instr_done), .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] aluFor(input logic [5:0] f);
    case (f)
      6'b100000: return 3'b010;
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      default:   return 3'b111;
    endcase
  endfunction

  // Runs one instruction from FETCH: fs wait cycles in fetch, ms wait cycles in the data access.
  task automatic runInstr(input logic [5:0] op, input logic [5:0] funct, input logic zero,
                          input int fs, input int ms);
    bit isR, isLw, isSw, isBeq, isBne, isAddi, isJ, legal, memPhase, done;
    int expLat, cyc, memStart;
    int nPcEn, nIr, nReg, nMemW, nIorD, nIll;
    logic [2:0] exeCtl;
    logic [1:0] decSrcB, lastPcSrc;
    logic wbDst, wbMem;
    isR   = (op == 6'b000000) && (funct == 6'b100000 || funct == 6'b100010 ||
             funct == 6'b100100 || funct == 6'b100101 || funct == 6'b101010);
    isLw  = (op == 6'b100011);
    isSw  = (op == 6'b101011);
    isBeq = (op == 6'b000100);
    isBne = BNE_EN && (op == 6'b000101);
    isAddi = (op == 6'b001000);
    isJ   = (op == 6'b000010);
    legal = isR || isLw || isSw || isBeq || isBne || isAddi || isJ;
    memPhase = isLw || isSw;
    memStart = fs + 3;
    if (isR || isAddi || isSw)       expLat = 4;
    else if (isLw)                   expLat = 5;
    else if (isBeq || isBne || isJ)  expLat = 3;
    else                             expLat = 2;
    expLat += fs + (memPhase ? ms : 0);

    Op = op; Funct = funct; Zero = zero;
    nPcEn = 0; nIr = 0; nReg = 0; nMemW = 0; nIorD = 0; nIll = 0;
    exeCtl = 3'bx; decSrcB = 2'bx; lastPcSrc = 2'bx; wbDst = 1'bx; wbMem = 1'bx;
    cyc = 0; done = 0;
    while (!done && cyc < 40) begin
      if (cyc < fs)                                              mem_ready = 1'b0;
      else if (cyc == fs)                                        mem_ready = 1'b1;
      else if (memPhase && cyc >= memStart && cyc < memStart + ms) mem_ready = 1'b0;
      else if (memPhase && cyc == memStart + ms)                 mem_ready = 1'b1;
      else                                                       mem_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      nPcEn += int'(PCEn); nIr += int'(IRWrite); nReg += int'(RegWrite);
      nMemW += int'(MemWrite); nIorD += int'(IorD); nIll += int'(illegal_op);
      if (cyc == fs + 1) decSrcB = ALUSrcB;
      if (cyc == fs + 2) exeCtl = ALUControl;
      if (RegWrite) begin wbDst = RegDst; wbMem = MemtoReg; end
      if (instr_done) begin done = 1; lastPcSrc = PCSrc; end
      @(posedge clk); #1;
      cyc++;
    end
    $display("[TB] op=%b funct=%b zero=%0d fs=%0d ms=%0d cycles=%0d", op, funct, zero, fs, ms, cyc);
    check("latency", cyc, expLat);
    check("illegal_op count", nIll, legal ? 0 : 1);
    check("IRWrite count", nIr, 1);
    check("PCEn count", nPcEn, 1 + int'(isJ) + int'(isBeq && zero) + int'(isBne && !zero));
    check("RegWrite count", nReg, int'(isR || isAddi || isLw));
    check("MemWrite count", nMemW, isSw ? ms + 1 : 0);
    check("IorD count", nIorD, memPhase ? ms + 1 : 0);
    check("DECODE ALUSrcB", decSrcB, 2'b11);
    if (isR) check("EXECUTE ALUControl", exeCtl, aluFor(funct));
    if (isR || isAddi || isLw) begin
      check("WB RegDst", wbDst, isR);
      check("WB MemtoReg", wbMem, isLw);
    end
    if (isBeq || isBne) check("BRANCH PCSrc", lastPcSrc, 2'b01);
    if (isJ) check("JUMP PCSrc", lastPcSrc, 2'b10);
  endtask

  initial begin
    logic [5:0] opList [9];
    logic [5:0] fnList [5];
    logic [5:0] rop, rfn;
    opList = '{6'b000000, 6'b000000, 6'b100011, 6'b101011, 6'b000100,
               6'b000101, 6'b001000, 6'b000010, 6'b111111};
    fnList = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};

    // Reset values, with mem_ready high to show fetch strobes are squashed.
    reset = 1'b1; Op = 6'b0; Funct = 6'b0; Zero = 1'b0; mem_ready = 1'b1;
    #2;
    check("reset IRWrite", IRWrite, 1'b0);
    check("reset PCEn", PCEn, 1'b0);
    check("reset ALUSrcB", ALUSrcB, 2'b01);
    check("reset ALUControl", ALUControl, 3'b010);
    check("reset instr_done", instr_done, 1'b0);
    @(posedge clk); #1;
    check("reset strobes", {MemWrite, RegWrite, illegal_op, IorD, ALUSrcA, PCSrc}, 0);
    reset = 1'b0;

    // Directed cases from the functional description.
    runInstr(6'b000000, 6'b100000, 1'b0, 0, 0);  // add
    runInstr(6'b100011, 6'b000000, 1'b0, 0, 2);  // lw, 2 wait cycles
    runInstr(6'b000100, 6'b000000, 1'b1, 0, 0);  // beq taken
    runInstr(6'b000100, 6'b000000, 1'b0, 0, 0);  // beq not taken
    runInstr(6'b111111, 6'b000000, 1'b0, 0, 0);  // illegal op
    runInstr(6'b000000, 6'b000111, 1'b0, 1, 0);  // illegal funct
    runInstr(6'b000101, 6'b000000, 1'b0, 0, 0);  // bne
    runInstr(6'b101011, 6'b000000, 1'b0, 2, 1);  // sw with waits

    // Reset asserted while MEMWRITE is stalled.
    Op = 6'b101011; Zero = 1'b0;
    for (int c = 0; c < 3; c++) begin
      mem_ready = 1'b1;
      @(posedge clk); #1;
    end
    mem_ready = 1'b0;
    @(negedge clk);
    check("MEMWRITE before reset", {MemWrite, IorD}, 2'b11);
    #1 reset = 1'b1;
    #1;
    check("reset MemWrite", MemWrite, 1'b0);
    check("reset IorD", IorD, 1'b0);
    check("reset mid ALUSrcB", ALUSrcB, 2'b01);
    check("reset mid instr_done", instr_done, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    runInstr(6'b000000, 6'b100010, 1'b0, 0, 0);  // sub right after release

    for (int n = 0; n < 80; n++) begin
      rop = opList[$urandom_range(0, 8)];
      if ($urandom_range(0, 5) == 0) rop = 6'($urandom);
      rfn = fnList[$urandom_range(0, 4)];
      if ($urandom_range(0, 6) == 0) rfn = 6'($urandom);
      runInstr(rop, rfn, 1'($urandom_range(0, 1)), $urandom_range(0, 2), $urandom_range(0, 2));
    end

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
